ksa_gen: RTL

Parametrised RC4 key-scheduling engine that drives a single-port synchronous S-box memory. The S-box size, key length and an optional built-in identity-fill phase are all set by parameters. It succeeds the fixed 256-entry, 3-byte-key KSA stage. It sits between the top-level switch/key glue and the S-box RAM, and hands off to the PRGA stage through its ready/enable handshake.

---
 rtl/ksa_gen.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/ksa_gen.sv
// RC4 key-scheduling engine driving a single-port S-box RAM with a registered read address.
// Optionally identity-fills the S-box, then runs one fixed 6-cycle swap per entry.
module ksa_gen #(
   parameter int ADDR_W  = 8,
   parameter int KEY_LEN = 3,
   parameter int DO_INIT = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   output logic                   rdy,
   input  logic [8*KEY_LEN-1:0]   key,
   output logic [ADDR_W-1:0]      addr,
   input  logic [ADDR_W-1:0]      rddata,
   output logic [ADDR_W-1:0]      wrdata,
   output logic                   wren
);

   localparam int KI_W = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_INIT, S_RD_I, S_WT_I, S_RD_J, S_WT_J, S_WR_I, S_WR_J
   } state_t;

   state_t                 state_q;
   logic                   rdy_q;
   logic                   wren_q;
   logic [ADDR_W-1:0]      addr_q;
   logic [ADDR_W-1:0]      wrdata_q;
   logic [ADDR_W-1:0]      i_q;
   logic [ADDR_W-1:0]      j_q;
   logic [ADDR_W-1:0]      si_q;
   logic [KI_W-1:0]        kidx_q;
   logic [8*KEY_LEN-1:0]   key_q;

   logic [7:0]             key_bytes [KEY_LEN];
   logic [7:0]             kbyte;
   logic [ADDR_W-1:0]      kb;
   logic [ADDR_W-1:0]      i_d;
   logic [ADDR_W-1:0]      j_d;
   logic                   i_last;
   logic                   kidx_last;

   // Byte 0 of the key sits in the most significant byte of the vector.
   generate
      for (genvar gi = 0; gi < KEY_LEN; gi++) begin : g_key_byte
         assign key_bytes[gi] = key_q[8*(KEY_LEN-1-gi) +: 8];
      end
   endgenerate

   assign kbyte     = key_bytes[kidx_q];
   assign kb        = kbyte[ADDR_W-1:0];
   assign i_d       = i_q + ADDR_W'(1);
   assign j_d       = j_q + rddata + kb;
   assign i_last    = (i_q == '1);
   assign kidx_last = (kidx_q == KI_W'(KEY_LEN-1));

   assign rdy    = rdy_q;
   assign wren   = wren_q;
   assign addr   = addr_q;
   assign wrdata = wrdata_q;

   // State names the memory operation being driven during the current cycle;
   // each transition registers the outputs for the next one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         rdy_q    <= 1'b1;
         wren_q   <= 1'b0;
         addr_q   <= '0;
         wrdata_q <= '0;
         i_q      <= '0;
         j_q      <= '0;
         si_q     <= '0;
         kidx_q   <= '0;
         key_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (en) begin
                  key_q    <= key;
                  i_q      <= '0;
                  j_q      <= '0;
                  kidx_q   <= '0;
                  rdy_q    <= 1'b0;
                  addr_q   <= '0;
                  wrdata_q <= '0;
                  if (DO_INIT != 0) begin
                     wren_q  <= 1'b1;
                     state_q <= S_INIT;
                  end else begin
                     wren_q  <= 1'b0;
                     state_q <= S_RD_I;
                  end
               end
            end
            S_INIT: begin
               if (i_last) begin
                  i_q     <= '0;
                  addr_q  <= '0;
                  wren_q  <= 1'b0;
                  state_q <= S_RD_I;
               end else begin
                  i_q      <= i_d;
                  addr_q   <= i_d;
                  wrdata_q <= i_d;
               end
            end
            S_RD_I: state_q <= S_WT_I;
            S_WT_I: begin
               si_q    <= rddata;
               j_q     <= j_d;
               addr_q  <= j_d;
               state_q <= S_RD_J;
            end
            S_RD_J: state_q <= S_WT_J;
            S_WT_J: begin
               addr_q   <= i_q;
               wrdata_q <= rddata;
               wren_q   <= 1'b1;
               state_q  <= S_WR_I;
            end
            S_WR_I: begin
               addr_q   <= j_q;
               wrdata_q <= si_q;
               state_q  <= S_WR_J;
            end
            S_WR_J: begin
               wren_q <= 1'b0;
               if (i_last) begin
                  addr_q  <= '0;
                  rdy_q   <= 1'b1;
                  state_q <= S_IDLE;
               end else begin
                  i_q     <= i_d;
                  kidx_q  <= kidx_last ? '0 : kidx_q + KI_W'(1);
                  addr_q  <= i_d;
                  state_q <= S_RD_I;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
